q2_lcd: RTL and testbench
=========================

Name: q2_lcd

Overview:
- Memory-mapped character-display peripheral on the q2 memory bus, downstream of the CPU.
- Decodes CPU writes to the display address using the display command encoding: set-address, clear, and character data. Other commands are ignored.
- Queues decoded operations in a small FIFO and drives an 8-bit HD44780-style LCD (write-only) with correct enable/delay timing, including a power-up init sequence.
- Reads of the display address return a status word; bit 0 is FIFO-full.

Parameters:
- ADDR, 12'hFFF, bus address of the display.
- DEPTH_LOG2, 3, log2 of FIFO depth (8 entries of 9 bits: {rs, byte}).
- INIT_CYCLES, 15000, power-up wait after reset before the first init command.
- E_CYCLES, 1, clocks lcd_e is held high per transfer.
- CMD_CYCLES, 40, post-pulse wait for normal commands and data.
- CLR_CYCLES, 1600, post-pulse wait for the clear command (rs=0, byte=8'h01).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- abus  in  12  CPU address bus.
- dbus_in  in  12  CPU write data.
- dbus_out  out  12  read data: {11'h7FF, full}.
- dbus_oe  out  1  combinational: rdm && abus==ADDR. Top level tristates dbus with it.
- wrm  in  1  CPU write strobe; may stay high for several clocks.
- rdm  in  1  CPU read strobe.
- lcd_rs  out  1  LCD register select (1 = data).
- lcd_e  out  1  LCD enable.
- lcd_db  out  8  LCD data bus.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.

Behaviour:
- **Reset** (synchronous): all of the following on the next edge.
  - FIFO emptied, wr_q=0.
  - lcd_e=0, lcd_rs=0, lcd_db=0.
  - FSM enters POWERUP with a zeroed counter; busy=1.
  - Asserting rst mid-transfer drops lcd_e on that edge and restarts the init sequence.
- **Write detect**: wr_q registers wrm. A write is accepted on a cycle with wrm && !wr_q && abus==ADDR. Exactly one event per strobe, data sampled from dbus_in on that cycle.
- **Command decode** (d = dbus_in):
  - d[8]=1, d[7]=1: push {0, 1'b1, d[6:0]}, i.e. set DDRAM address 8'h80|addr.
  - d[8]=1, d[7]=0, d[0]=1: push {0, 8'h01}, i.e. clear.
  - d[8]=1, otherwise: no push, no effect.
  - d[8]=0: push {1, d[7:0]}, i.e. character data.
- **FIFO**:
  - Push is checked against full as registered at the start of the cycle. A push while full is silently dropped, even if a pop occurs in the same cycle.
  - Pop and a non-full push in the same cycle both take effect; the count is unchanged.
  - Pointers wrap modulo 2^DEPTH_LOG2. full = count == 2^DEPTH_LOG2.
  - The FIFO accepts pushes during POWERUP/INIT; entries wait until IDLE.
- **FSM**:
  - POWERUP: count to INIT_CYCLES-1, then go to INIT with idx=0.
  - INIT: send the fixed sequence 8'h38, 8'h0C, 8'h06, 8'h01 with rs=0. Each uses SETUP, PULSE, WAIT, then returns to INIT with idx+1. After idx 3 completes, go to IDLE.
  - IDLE: if the FIFO is non-empty, pop the head, latch rs/byte onto lcd_rs/lcd_db, and go to SETUP. Otherwise stay.
  - SETUP: 1 cycle with lcd_e=0 and rs/db stable, then PULSE.
  - PULSE: lcd_e=1 for E_CYCLES cycles, then WAIT with lcd_e=0.
  - WAIT: wait CLR_CYCLES if rs=0 && byte==8'h01, else CMD_CYCLES. Return to INIT while init is in progress, else IDLE.
- **Timing**:
  - lcd_rs/lcd_db hold their value from SETUP until the next SETUP.
  - Minimum per-transfer latency from IDLE pop to next IDLE: 1+E_CYCLES+CMD_CYCLES clocks.
- **Read path**: purely combinational, no side effects. Reads 12'hFFE when not full, 12'hFFF when full.

Test Plan:
- Reset with INIT_CYCLES=10, CMD_CYCLES=4, CLR_CYCLES=8 -> after 10 clocks, four lcd_e pulses latching 38, 0C, 06, 01 with rs=0; gap after 01 is ≥8 clocks; then IDLE, busy=0.
- After init, write 12'h041 ('A') with wrm held 3 clocks -> exactly one lcd_e pulse, rs=1, db=8'h41.
- Write 12'h1C5 -> db=8'hC5, rs=0. Write 12'h101 -> db=8'h01, rs=0, with a CLR_CYCLES wait. Write 12'h100 -> no pulse, FIFO count unchanged.
- During POWERUP, write 9 characters 'a'..'i' back-to-back -> first 8 are output in order after init; 'i' is dropped. Reading ADDR returns 12'hFFF while full and 12'hFFE afterwards.
- With rdm=1 and abus=12'h123 -> dbus_oe=0. With abus=ADDR, rdm=1 -> dbus_oe=1 and FIFO/FSM state is unchanged.
- Assert rst while lcd_e=1 during a data pulse -> lcd_e=0 next edge, FIFO empty, status 12'hFFE, and the init sequence repeats from POWERUP.

Source files
------------

// File: rtl/q2_lcd.sv
// Memory-mapped HD44780-style character display controller on the q2 bus.
// CPU writes are decoded into LCD operations, queued, and replayed with enable/delay timing.
module q2_lcd #(
    parameter logic [11:0] ADDR        = 12'hFFF,
    parameter int          DEPTH_LOG2  = 3,
    parameter int          INIT_CYCLES = 15000,
    parameter int          E_CYCLES    = 1,
    parameter int          CMD_CYCLES  = 40,
    parameter int          CLR_CYCLES  = 1600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] abus,
    input  logic [11:0] dbus_in,
    output logic [11:0] dbus_out,
    output logic        dbus_oe,
    input  logic        wrm,
    input  logic        rdm,
    output logic        lcd_rs,
    output logic        lcd_e,
    output logic [7:0]  lcd_db,
    output logic        busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(INIT_CYCLES + CLR_CYCLES + CMD_CYCLES + E_CYCLES + 2);

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Bus write detect and command decode
    // ------------------------------------------------------------------
    logic       wr_q_reg;
    logic       accept;
    logic       push_req;
    logic [8:0] push_data;
    logic       unused_bits;

    assign accept      = wrm && !wr_q_reg && (abus == ADDR);
    assign unused_bits = ^dbus_in[11:9];

    always_ff @(posedge clk) begin
        if (rst) wr_q_reg <= 1'b0;
        else     wr_q_reg <= wrm;
    end

    always_comb begin
        push_req  = 1'b0;
        push_data = 9'h000;
        if (accept) begin
            if (!dbus_in[8]) begin
                push_req  = 1'b1;
                push_data = {1'b1, dbus_in[7:0]};
            end else if (dbus_in[7]) begin
                push_req  = 1'b1;
                push_data = {1'b0, 1'b1, dbus_in[6:0]};
            end else if (dbus_in[0]) begin
                push_req  = 1'b1;
                push_data = {1'b0, 8'h01};
            end
        end
    end

    // ------------------------------------------------------------------
    // Operation FIFO, entries are {rs, byte}
    // ------------------------------------------------------------------
    logic [8:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic                  full;
    logic                  empty;
    logic                  push_ok;
    logic                  pop;

    assign full    = (count_reg == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty   = (count_reg == '0);
    // Full is judged on the registered count, so a same-cycle pop cannot rescue a push.
    assign push_ok = push_req && !full;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display sequencer
    // ------------------------------------------------------------------
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       idx_reg, idx_next;
    logic             init_reg, init_next;
    logic             rs_reg, rs_next;
    logic [7:0]       db_reg, db_next;
    logic             e_reg, e_next;
    logic [CNT_W-1:0] wait_last;

    function automatic logic [7:0] init_byte(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // Clear needs the long settle time; everything else uses the normal command delay.
    assign wait_last = (!rs_reg && db_reg == 8'h01) ? CNT_W'(CLR_CYCLES - 1)
                                                    : CNT_W'(CMD_CYCLES - 1);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        init_next  = init_reg;
        rs_next    = rs_reg;
        db_next    = db_reg;
        pop        = 1'b0;
        case (state_reg)
            ST_POWERUP: begin
                if (cnt_reg == CNT_W'(INIT_CYCLES - 1)) begin
                    state_next = ST_INIT;
                    cnt_next   = '0;
                    idx_next   = 2'd0;
                    init_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_INIT: begin
                rs_next    = 1'b0;
                db_next    = init_byte(idx_reg);
                cnt_next   = '0;
                state_next = ST_SETUP;
            end
            ST_IDLE: begin
                if (!empty) begin
                    pop               = 1'b1;
                    {rs_next, db_next} = mem[rd_ptr_reg];
                    cnt_next          = '0;
                    state_next        = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_next   = '0;
                state_next = ST_PULSE;
            end
            ST_PULSE: begin
                if (cnt_reg == CNT_W'(E_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = ST_WAIT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_reg == wait_last) begin
                    cnt_next = '0;
                    if (init_reg && idx_reg != 2'd3) begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = ST_INIT;
                    end else begin
                        init_next  = 1'b0;
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_POWERUP;
        endcase
        e_next = (state_next == ST_PULSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_POWERUP;
            cnt_reg   <= '0;
            idx_reg   <= 2'd0;
            init_reg  <= 1'b1;
            rs_reg    <= 1'b0;
            db_reg    <= 8'h00;
            e_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            init_reg  <= init_next;
            rs_reg    <= rs_next;
            db_reg    <= db_next;
            e_reg     <= e_next;
        end
    end

    assign lcd_rs   = rs_reg;
    assign lcd_db   = db_reg;
    assign lcd_e    = e_reg;
    assign busy     = (state_reg != ST_IDLE) || !empty;
    assign dbus_out = {11'h7FF, full};
    assign dbus_oe  = rdm && (abus == ADDR);

endmodule

// File: tb/tb_q2_lcd.sv
// Randomized self-checking bench for q2_lcd: bus writes are decoded by a reference
// model into expected LCD transfers, and a monitor checks the observed pulses and timing.
module tb_q2_lcd;

    localparam logic [11:0] ADDR  = 12'hFFF;
    localparam int INIT_C = 10;
    localparam int E_C    = 1;
    localparam int CMD_C  = 4;
    localparam int CLR_C  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] abus, dbus_in, dbus_out;
    logic        dbus_oe, wrm, rdm;
    logic        lcd_rs, lcd_e, busy;
    logic [7:0]  lcd_db;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] obs_q[$];
    logic [8:0] exp_q[$];

    q2_lcd #(
        .ADDR(ADDR), .DEPTH_LOG2(3), .INIT_CYCLES(INIT_C),
        .E_CYCLES(E_C), .CMD_CYCLES(CMD_C), .CLR_CYCLES(CLR_C)
    ) dut (
        .clk(clk), .rst(rst), .abus(abus), .dbus_in(dbus_in),
        .dbus_out(dbus_out), .dbus_oe(dbus_oe), .wrm(wrm), .rdm(rdm),
        .lcd_rs(lcd_rs), .lcd_e(lcd_e), .lcd_db(lcd_db), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // ---------------- pulse monitor ----------------
    int         cyc = 0;
    int         rise_cyc, prev_rise, rel_cyc;
    logic       in_pulse = 1'b0, have_prev = 1'b0, prev_clr = 1'b0, first_pend = 1'b0;
    logic [8:0] rise_val;

    always @(posedge clk) begin
        cyc++;
        #2;
        if (rst) begin
            in_pulse   = 1'b0;
            have_prev  = 1'b0;
            first_pend = 1'b1;
            rel_cyc    = cyc;
        end else if (lcd_e && !in_pulse) begin
            in_pulse = 1'b1;
            rise_cyc = cyc;
            rise_val = {lcd_rs, lcd_db};
            obs_q.push_back(rise_val);
            if (first_pend) check("powerup_wait", (cyc - rel_cyc >= INIT_C) ? 1 : 0, 1);
            first_pend = 1'b0;
            if (have_prev)
                check("pulse_gap", (cyc - prev_rise >= 2 + E_C + (prev_clr ? CLR_C : CMD_C)) ? 1 : 0, 1);
            prev_rise = cyc;
            prev_clr  = (rise_val == 9'h001);
            have_prev = 1'b1;
        end else if (!lcd_e && in_pulse) begin
            in_pulse = 1'b0;
            check("e_width", cyc - rise_cyc, E_C);
            check("db_hold", {lcd_rs, lcd_db}, rise_val);
        end
    end

    // ---------------- reference model ----------------
    task automatic model_write(input logic [11:0] a, input logic [11:0] d);
        if (a == ADDR) begin
            if (!d[8])          exp_q.push_back({1'b1, d[7:0]});
            else if (d[7])      exp_q.push_back({1'b0, 8'h80 | {1'b0, d[6:0]}});
            else if (d[0])      exp_q.push_back(9'h001);
        end
    endtask

    task automatic push_init_seq();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h001);
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [11:0] d, input int hold, input int gap);
        @(negedge clk);
        abus = a; dbus_in = d; wrm = 1'b1;
        repeat (hold) @(negedge clk);
        wrm = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", busy, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic compare_queues(input string tag);
        int n;
        check({tag, "_len"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_item"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sz;
        logic [11:0] a, d;
        rst = 1'b1; wrm = 1'b0; rdm = 1'b0; abus = 12'h000; dbus_in = 12'h000;
        repeat (3) @(negedge clk);
        check("rst_e", lcd_e, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_db", lcd_db, 0);
        check("rst_busy", busy, 1);
        check("rst_status", dbus_out, 12'hFFE);
        check("rst_oe", dbus_oe, 0);
        rst = 1'b0;
        push_init_seq();

        // Fill during power-up: the ninth character must be dropped.
        for (int i = 0; i < 9; i++) begin
            bus_write(ADDR, 12'h061 + 12'(i), 1, 1);
            if (i < 8) model_write(ADDR, 12'h061 + 12'(i));
        end
        check("full_status", dbus_out, 12'hFFF);
        rdm = 1'b1; abus = ADDR;
        @(negedge clk);
        check("full_oe", dbus_oe, 1);
        rdm = 1'b0;
        wait_idle(2000);
        compare_queues("fill");
        check("drain_status", dbus_out, 12'hFFE);
        check("idle_busy", busy, 0);

        // Directed commands, including a held strobe and the ignored command.
        bus_write(ADDR, 12'h041, 3, 1); model_write(ADDR, 12'h041);
        bus_write(ADDR, 12'h1C5, 1, 1); model_write(ADDR, 12'h1C5);
        bus_write(ADDR, 12'h101, 1, 1); model_write(ADDR, 12'h101);
        wait_idle(2000);
        compare_queues("directed");
        bus_write(ADDR, 12'h100, 1, 1);
        repeat (10) @(negedge clk);
        check("ignored_pulses", obs_q.size(), 0);
        check("ignored_busy", busy, 0);

        // Read path: no side effects.
        rdm = 1'b1; abus = 12'h123;
        @(negedge clk);
        check("oe_other_addr", dbus_oe, 0);
        abus = ADDR;
        @(negedge clk);
        check("oe_addr", dbus_oe, 1);
        check("read_status", dbus_out, 12'hFFE);
        repeat (5) @(negedge clk);
        check("read_busy", busy, 0);
        check("read_pulses", obs_q.size(), 0);
        rdm = 1'b0;

        // Randomized bursts of at most 8 writes from idle never overflow the FIFO.
        for (int b = 0; b < 25; b++) begin
            sz = $urandom_range(1, 8);
            for (int k = 0; k < sz; k++) begin
                a = ($urandom_range(0, 5) == 0) ? 12'h123 : ADDR;
                d = 12'($urandom);
                if ($urandom_range(0, 1) == 1) d[8] = 1'b1;
                bus_write(a, d, $urandom_range(1, 3), $urandom_range(1, 2));
                model_write(a, d);
            end
            wait_idle(3000);
        end
        compare_queues("random");

        // Reset during a data pulse flushes the FIFO and restarts init.
        for (int i = 0; i < 3; i++) bus_write(ADDR, 12'h030 + 12'(i), 1, 1);
        sz = 0;
        while (!lcd_e && sz < 200) begin
            @(negedge clk);
            sz++;
        end
        check("pulse_seen", lcd_e, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_e", lcd_e, 0);
        check("rst_mid_busy", busy, 1);
        check("rst_mid_status", dbus_out, 12'hFFE);
        obs_q.delete();
        exp_q.delete();
        rst = 1'b0;
        push_init_seq();
        wait_idle(2000);
        compare_queues("reinit");
        check("reinit_status", dbus_out, 12'hFFE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
